// File: rtl/game_pkg.sv
// game_pkg: shared game state codes, RGB444 colours, menu FSM states and a box outline helper.
package game_pkg;
  localparam logic [3:0] ST_MENU      = 4'b0000;
  localparam logic [3:0] ST_PLAYER    = 4'b0001;
  localparam logic [3:0] ST_ENEMY     = 4'b1000;
  localparam logic [3:0] ST_GAME_OVER = 4'b1111;
  localparam logic [11:0] COL_CLEAR  = 12'h000;
  localparam logic [11:0] COL_CURSOR = 12'hFF0;
  localparam logic [11:0] COL_BOX    = 12'hF80;
  typedef enum logic [1:0] {MS_IDLE, MS_ARM, MS_SELECT, MS_DONE} menu_state_t;
  // True on the b-wide ring just inside the w x ht rectangle at (x0, y0).
  function automatic logic on_outline(input logic [11:0] h, v, x0, y0, w, ht, b);
    return h >= x0 && h < x0 + w && v >= y0 && v < y0 + ht &&
           !(h >= x0 + b && h < x0 + w - b && v >= y0 + b && v < y0 + ht - b);
  endfunction
endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-register rising-edge detector with synchronous active-low reset.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic prev;
  always_ff @(posedge clk)
    prev <= rst ? d : 1'b0;
  assign rise = d & ~prev;
endmodule

// File: rtl/action_menu.sv
// action_menu: option selector with cursor FSM and box overlay.
// Define ACTION_MENU_WRAP_EN to make the cursor wrap instead of saturate.
module action_menu import game_pkg::*; #(
  parameter logic [3:0] MY_STATE = ST_MENU,
  parameter int N_OPTIONS = 4,
  parameter int BOX_X0    = 40,
  parameter int BOX_PITCH = 240,
  parameter int BOX_Y     = 620,
  parameter int BOX_W     = 200,
  parameter int BOX_H     = 60,
  parameter int BORDER    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic [3:0]  state_in,
  input  logic [1:0]  key_input_in,
  input  logic        decide_in,
  output logic        busy_out,
  output logic        finished_out,
  output logic [1:0]  choice_out,
  output logic [11:0] pixel_out
);
  localparam logic [1:0] LAST = 2'(N_OPTIONS - 1);
  logic left_rise, right_rise, decide_rise, active;
  logic [1:0] cursor, cursor_nx, choice_nx, cur_dec, cur_inc;
  logic finished_nx;
  logic [11:0] pixel_nx;
  menu_state_t state, state_nx;
  edge_detect u_left   (.clk(clk), .rst(rst), .d(key_input_in[0]), .rise(left_rise));
  edge_detect u_right  (.clk(clk), .rst(rst), .d(key_input_in[1]), .rise(right_rise));
  edge_detect u_decide (.clk(clk), .rst(rst), .d(decide_in),       .rise(decide_rise));
  assign active   = state_in == MY_STATE;
  assign busy_out = state == MS_ARM || state == MS_SELECT;
`ifdef ACTION_MENU_WRAP_EN
  assign cur_dec = cursor == 2'd0 ? LAST : cursor - 2'd1;
  assign cur_inc = cursor == LAST ? 2'd0 : cursor + 2'd1;
`else
  assign cur_dec = cursor == 2'd0 ? 2'd0 : cursor - 2'd1;
  assign cur_inc = cursor == LAST ? LAST : cursor + 2'd1;
`endif
  always_comb begin
    state_nx    = state;
    cursor_nx   = cursor;
    choice_nx   = choice_out;
    finished_nx = 1'b0;
    case (state)
      MS_IDLE: if (active) begin
        state_nx  = MS_ARM;
        cursor_nx = 2'd0;
      end
      MS_ARM: state_nx = !active ? MS_IDLE : !decide_in ? MS_SELECT : MS_ARM;
      // A decide edge commits the cursor as it stood before any same-cycle key edge.
      MS_SELECT: if (!active) state_nx = MS_IDLE;
      else if (decide_rise) begin
        state_nx    = MS_DONE;
        choice_nx   = cursor;
        finished_nx = 1'b1;
      end else if (left_rise ^ right_rise) cursor_nx = left_rise ? cur_dec : cur_inc;
      MS_DONE: state_nx = active ? MS_DONE : MS_IDLE;
      default: state_nx = MS_IDLE;
    endcase
  end
  always_comb begin
    pixel_nx = COL_CLEAR;
    for (int i = 0; i < 4; i++)
      if (busy_out && i < N_OPTIONS &&
          on_outline({1'b0, hcount_in}, {2'b0, vcount_in}, 12'(BOX_X0 + i * BOX_PITCH),
                     12'(BOX_Y), 12'(BOX_W), 12'(BOX_H), 12'(BORDER)))
        pixel_nx = 2'(i) == cursor ? COL_CURSOR : COL_BOX;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state        <= MS_IDLE;
      cursor       <= 2'd0;
      choice_out   <= 2'd0;
      finished_out <= 1'b0;
      pixel_out    <= COL_CLEAR;
    end else begin
      state        <= state_nx;
      cursor       <= cursor_nx;
      choice_out   <= choice_nx;
      finished_out <= finished_nx;
      pixel_out    <= pixel_nx;
    end
endmodule

// File: tb/tb_action_menu.sv
// tb_action_menu: randomized scoreboard bench for action_menu against a behavioural menu model.
module tb_action_menu;
  localparam int N = 4;
  logic clk = 0, rst = 0, decide_in = 0;
  logic [10:0] hcount_in = 0;
  logic [9:0] vcount_in = 0;
  logic [3:0] state_in = 4'd1;
  logic [1:0] key_input_in = 0;
  logic busy_out, finished_out;
  logic [1:0] choice_out;
  logic [11:0] pixel_out;
  int checks = 0, errors = 0;
  action_menu dut (
    .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .state_in(state_in), .key_input_in(key_input_in), .decide_in(decide_in),
    .busy_out(busy_out), .finished_out(finished_out), .choice_out(choice_out),
    .pixel_out(pixel_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Behavioural model: phase 0 off, 1 waiting for confirm release, 2 choosing, 3 committed.
  int ph = 0, cur = 0, ch = 0;
  bit fin = 0, started = 0, pl = 0, pr = 0, pd = 0;
  logic [11:0] epix = 0;
  int exp_q[$];
  function automatic int move(input int c, input int d);
`ifdef ACTION_MENU_WRAP_EN
    return (c + d + N) % N;
`else
    return c + d < 0 ? 0 : c + d > N - 1 ? N - 1 : c + d;
`endif
  endfunction
  function automatic bit ring(input int h, input int v, input int i);
    int x0 = 40 + 240 * i;
    return h >= x0 && h < x0 + 200 && v >= 620 && v < 680 &&
           !(h >= x0 + 4 && h < x0 + 196 && v >= 624 && v < 676);
  endfunction
  always @(posedge clk) begin
    bit kl, kr, kd, act;
    started = 1;
    fin = 0;
    epix = 12'h000;
    if (!rst) begin
      ph = 0; cur = 0; ch = 0; pl = 0; pr = 0; pd = 0;
    end else begin
      kl = key_input_in[0] && !pl;
      kr = key_input_in[1] && !pr;
      kd = decide_in && !pd;
      act = state_in == 4'd0;
      if (ph == 1 || ph == 2)
        for (int i = 0; i < N; i++)
          if (ring(hcount_in, vcount_in, i)) epix = i == cur ? 12'hFF0 : 12'hF80;
      if (ph == 0) begin
        if (act) begin ph = 1; cur = 0; end
      end else if (!act) ph = 0;
      else if (ph == 1) begin
        if (!decide_in) ph = 2;
      end else if (ph == 2) begin
        if (kd) begin ch = cur; fin = 1; exp_q.push_back(cur); ph = 3; end
        else if (kl != kr) cur = move(cur, kl ? -1 : 1);
      end
      pl = key_input_in[0]; pr = key_input_in[1]; pd = decide_in;
    end
  end
  always @(negedge clk) if (started) begin
    chk("busy", {11'd0, busy_out}, {11'd0, ph == 1 || ph == 2});
    chk("finished", {11'd0, finished_out}, {11'd0, fin});
    chk("pixel", pixel_out, epix);
    chk("choice_hold", {10'd0, choice_out}, 12'(ch));
    if (finished_out) begin
      if (exp_q.size() == 0) chk("commit_unexpected", {10'd0, choice_out}, 12'hFFF);
      else chk("commit", {10'd0, choice_out}, 12'(exp_q.pop_front()));
    end
  end
  task automatic step(input logic [3:0] st, input logic [1:0] k, input logic d,
                      input int h = 0, input int v = 0);
    state_in = st; key_input_in = k; decide_in = d;
    hcount_in = 11'(h); vcount_in = 10'(v);
    @(posedge clk); #1;
  endtask
  task automatic enter();
    step(4'd1, 2'b00, 0); step(4'd0, 2'b00, 0); step(4'd0, 2'b00, 0);
  endtask
  initial begin
    #1;
    step(4'd1, 2'b00, 0); step(4'd1, 2'b00, 0);
    chk("reset_busy", {11'd0, busy_out}, 12'd0);
    chk("reset_pixel", pixel_out, 12'h000);
    rst = 1;
    enter();
    chk("s1_busy", {11'd0, busy_out}, 12'd1);
    step(4'd0, 2'b10, 0); step(4'd0, 2'b00, 0); step(4'd0, 2'b10, 0); step(4'd0, 2'b00, 0);
    step(4'd0, 2'b00, 1);
    chk("s1_fin", {11'd0, finished_out}, 12'd1);
    chk("s1_choice", {10'd0, choice_out}, 12'd2);
    step(4'd0, 2'b00, 0);
    chk("s1_fin_once", {11'd0, finished_out}, 12'd0);
    step(4'd1, 2'b00, 1); step(4'd0, 2'b00, 1); step(4'd0, 2'b00, 1);
    chk("s2_armed_busy", {11'd0, busy_out}, 12'd1);
    chk("s2_no_commit", {11'd0, finished_out}, 12'd0);
    step(4'd0, 2'b00, 0); step(4'd0, 2'b00, 1);
    chk("s2_choice", {10'd0, choice_out}, 12'd0);
    for (int w = 0; w < 2; w++) begin
      enter();
      for (int i = 0; i < 5; i++) begin
        step(4'd0, w ? 2'b01 : 2'b10, 0); step(4'd0, 2'b00, 0);
      end
      step(4'd0, 2'b00, 1);
    end
    enter();
    step(4'd0, 2'b10, 0); step(4'd0, 2'b00, 0); step(4'd0, 2'b11, 0); step(4'd0, 2'b00, 0);
    step(4'd0, 2'b10, 1);
    chk("s4_choice", {10'd0, choice_out}, 12'd1);
    enter();
    step(4'd0, 2'b10, 0); step(4'd0, 2'b00, 0); step(4'd1, 2'b00, 1, 280, 620);
    chk("s5_abort_busy", {11'd0, busy_out}, 12'd0);
    chk("s5_abort_fin", {11'd0, finished_out}, 12'd0);
    enter();
    step(4'd0, 2'b10, 0); step(4'd0, 2'b00, 0, 280, 620);
    chk("s6_cursor_box", pixel_out, 12'hFF0);
    step(4'd0, 2'b00, 0, 40, 620);
    chk("s6_other_box", pixel_out, 12'hF80);
    step(4'd0, 2'b00, 0, 140, 650);
    chk("s6_interior", pixel_out, 12'h000);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) != 0;
      step($urandom_range(0, 15) == 0 ? 4'd1 : 4'd0, 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 1023), $urandom_range(600, 700));
    end
    rst = 1;
    step(4'd1, 2'b00, 0); step(4'd1, 2'b00, 0);
    chk("queue_drained", 12'(exp_q.size()), 12'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
